// File: rtl/araddr_rr_scheduler.sv
// araddr_rr_scheduler: round-robin AXI AR arbiter with tag FIFO push and outstanding-burst limit
module araddr_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 28,
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [LEN_W-1:0]          m_arlen,
  output logic                      tag_wr_en,
  output logic [ID_W-1:0]           tag_wr_data,
  input  logic                      tag_wr_vld,
  input  logic                      burst_done,
  output logic [7:0]                outstanding,
  output logic                      err_underflow
);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;
  logic [ID_W-1:0] ptr, win, win_nxt;
  logic grant, hs;
  int best, off;
  assign hs = state == ISSUE && m_arready;
  assign grant = state == IDLE && |req_valid && tag_wr_vld && outstanding < 8'(MAX_OUT);
  assign m_arvalid = state == ISSUE;
  assign tag_wr_en = hs;
  assign tag_wr_data = hs ? win : '0;
  always_comb begin
    win_nxt = '0;
    best = NUM_REQ;
    off = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req_valid[i] && off < best) begin
        best = off;
        win_nxt = ID_W'(i);
      end
    end
  end
  always_comb state_nxt = grant ? ISSUE : hs ? IDLE : state;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ptr <= '0;
      win <= '0;
      m_araddr <= '0;
      m_arlen <= '0;
      req_ready <= '0;
      outstanding <= '0;
      err_underflow <= 1'b0;
    end else begin
      req_ready <= grant ? NUM_REQ'(1) << win_nxt : '0;
      if (grant) begin
        win <= win_nxt;
        m_araddr <= req_addr[win_nxt*ADDR_W +: ADDR_W];
        m_arlen <= req_len[win_nxt*LEN_W +: LEN_W];
      end
      if (hs) ptr <= win == ID_W'(NUM_REQ-1) ? '0 : win + ID_W'(1);
      if (hs && !burst_done) outstanding <= outstanding + 8'd1;
      else if (burst_done && !hs) begin
        if (outstanding == 8'd0) err_underflow <= 1'b1;
        else outstanding <= outstanding - 8'd1;
      end
    end
endmodule

// File: tb/tb_araddr_rr_scheduler.sv
// tb_araddr_rr_scheduler: directed self-checking bench for araddr_rr_scheduler
module tb_araddr_rr_scheduler;
  localparam int N = 4, IW = 4, AW = 28, LW = 8, MO = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*LW-1:0] req_len = '0;
  logic m_arvalid, m_arready = 1'b0;
  logic [AW-1:0] m_araddr;
  logic [LW-1:0] m_arlen;
  logic tag_wr_en, tag_wr_vld = 1'b1, burst_done = 1'b0, err_underflow;
  logic [IW-1:0] tag_wr_data;
  logic [7:0] outstanding;
  int checks = 0, failures = 0;
  araddr_rr_scheduler #(.NUM_REQ(N), .ID_W(IW), .ADDR_W(AW), .LEN_W(LW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .tag_wr_en(tag_wr_en), .tag_wr_data(tag_wr_data),
    .tag_wr_vld(tag_wr_vld), .burst_done(burst_done), .outstanding(outstanding),
    .err_underflow(err_underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arlen", m_arlen, 0);
    chk("rst_tag_en", tag_wr_en, 0);
    chk("rst_tag_data", tag_wr_data, 0);
    chk("rst_outs", outstanding, 0);
    chk("rst_err", err_underflow, 0);
    rst_n = 1'b1;
    req_valid = 4'b0100;
    req_addr[2*AW +: AW] = 28'h0001000;
    req_len[2*LW +: LW] = 8'h0F;
    m_arready = 1'b1;
    tick();
    chk("single_ready", req_ready, 4'b0100);
    chk("single_arvalid", m_arvalid, 1);
    chk("single_araddr", m_araddr, 28'h0001000);
    chk("single_arlen", m_arlen, 8'h0F);
    chk("single_tag_en", tag_wr_en, 1);
    chk("single_tag_data", tag_wr_data, 2);
    req_valid = '0;
    tick();
    chk("single_outs", outstanding, 1);
    chk("single_arvalid_lo", m_arvalid, 0);
    chk("single_ready_lo", req_ready, 0);
    chk("single_tag_en_lo", tag_wr_en, 0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("done_outs", outstanding, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_ready", req_ready, 4'(1) << (g % 4));
      chk("rr_arvalid", m_arvalid, 1);
      chk("rr_tag_en", tag_wr_en, 1);
      chk("rr_tag_data", tag_wr_data, g % 4);
      burst_done = 1'b1;
      tick();
      burst_done = 1'b0;
      chk("rr_hs_arvalid", m_arvalid, 0);
      chk("rr_coincide_outs", outstanding, 0);
    end
    chk("rr_err", err_underflow, 0);
    req_valid = 4'b0010;
    req_addr[1*AW +: AW] = 28'hABCDE00;
    req_len[1*LW +: LW] = 8'h03;
    m_arready = 1'b0;
    tick();
    chk("bp_ready", req_ready, 4'b0010);
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_arvalid", m_arvalid, 1);
      chk("bp_araddr", m_araddr, 28'hABCDE00);
      chk("bp_arlen", m_arlen, 8'h03);
      chk("bp_no_tag", tag_wr_en, 0);
      tick();
    end
    m_arready = 1'b1;
    #1;
    chk("bp_tag_en", tag_wr_en, 1);
    chk("bp_tag_data", tag_wr_data, 1);
    tick();
    chk("bp_tag_once", tag_wr_en, 0);
    chk("bp_arvalid_lo", m_arvalid, 0);
    chk("bp_outs", outstanding, 1);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("lim_start_outs", outstanding, 0);
    req_valid = 4'b1111;
    tick();
    chk("lim_g1", req_ready, 4'b0100);
    tick();
    chk("lim_outs1", outstanding, 1);
    tick();
    chk("lim_g2", req_ready, 4'b1000);
    tick();
    chk("lim_outs2", outstanding, 2);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("lim_block_ready", req_ready, 0);
      chk("lim_block_arvalid", m_arvalid, 0);
    end
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk("lim_done_no_grant", m_arvalid, 0);
    chk("lim_done_outs", outstanding, 1);
    tick();
    chk("lim_g3", req_ready, 4'b0001);
    chk("lim_g3_arvalid", m_arvalid, 1);
    tick();
    chk("lim_outs3", outstanding, 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("lim_block2", m_arvalid, 0);
    end
    req_valid = '0;
    burst_done = 1'b1;
    tick();
    tick();
    burst_done = 1'b0;
    chk("drain_outs", outstanding, 0);
    chk("drain_err", err_underflow, 0);
    tag_wr_vld = 1'b0;
    req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("full_ready", req_ready, 0);
      chk("full_arvalid", m_arvalid, 0);
    end
    tag_wr_vld = 1'b1;
    tick();
    chk("full_release_ready", req_ready, 4'b0001);
    chk("full_release_arvalid", m_arvalid, 1);
    req_valid = '0;
    tick();
    chk("full_outs", outstanding, 1);
    burst_done = 1'b1;
    tick();
    chk("uf_outs_pre", outstanding, 0);
    chk("uf_err_pre", err_underflow, 0);
    tick();
    burst_done = 1'b0;
    chk("uf_err", err_underflow, 1);
    chk("uf_outs", outstanding, 0);
    tick();
    tick();
    chk("uf_sticky", err_underflow, 1);
    req_valid = 4'b0100;
    tick();
    chk("pre_rst_g1", req_ready, 4'b0100);
    req_valid = '0;
    tick();
    chk("pre_rst_outs", outstanding, 1);
    req_valid = 4'b0100;
    m_arready = 1'b0;
    tick();
    chk("pre_rst_arvalid", m_arvalid, 1);
    req_valid = '0;
    rst_n = 1'b0;
    m_arready = 1'b1;
    tick();
    chk("mid_rst_arvalid", m_arvalid, 0);
    chk("mid_rst_tag_en", tag_wr_en, 0);
    chk("mid_rst_outs", outstanding, 0);
    chk("mid_rst_err", err_underflow, 0);
    chk("mid_rst_ready", req_ready, 0);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    tick();
    chk("post_rst_ptr", req_ready, 4'b0001);
    chk("post_rst_tag", tag_wr_data, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/araddr_rr_scheduler.md
Name: araddr_rr_scheduler

Overview:
- Shares a single AXI read-address (AR) channel among NUM_REQ read requesters, such as the video read channels and frame-buffer fetchers, using round-robin arbitration.
- For each accepted AR handshake, pushes the winner's ID into the low araddr tag FIFO. The read-data return path uses that FIFO to route beats back to the right requester.
- Bounds the number of outstanding bursts, and blocks new grants when the tag FIFO cannot accept a write.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
ID_W, 4, tag width written to the tag FIFO; must satisfy 2^ID_W >= NUM_REQ
ADDR_W, 28, AXI read address width
LEN_W, 8, AXI burst length field width (arlen, beats-1)
MAX_OUT, 8, maximum outstanding bursts (1..255)

Ports:
clk  in  1  single clock; all logic on the rising edge
rst_n  in  1  synchronous reset, active low
req_valid  in  NUM_REQ  per-requester read request pending
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse to the granted requester
req_addr  in  NUM_REQ*ADDR_W  packed request addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*LEN_W  packed burst lengths; requester i uses bits [i*LEN_W +: LEN_W]
m_arvalid  out  1  AXI AR valid
m_arready  in  1  AXI AR ready
m_araddr  out  ADDR_W  AXI AR address
m_arlen  out  LEN_W  AXI AR length
tag_wr_en  out  1  tag FIFO write strobe
tag_wr_data  out  ID_W  tag FIFO write data: granted requester index, zero-extended
tag_wr_vld  in  1  tag FIFO can accept a write (high = space available)
burst_done  in  1  1-cycle pulse when the return path consumes the rlast of a burst
outstanding  out  8  current outstanding burst count
err_underflow  out  1  sticky: burst_done was seen while outstanding==0

Behaviour:
- Reset (rst_n=0 at a clk edge), sampled synchronously; all of the following take effect at that edge:
  - Outputs: req_ready=0, m_arvalid=0, m_araddr=0, m_arlen=0, tag_wr_en=0, tag_wr_data=0, outstanding=0, err_underflow=0.
  - Internal state: round-robin pointer=0, state=IDLE.
- Reset in mid-operation:
  - An AR in flight is dropped immediately (m_arvalid=0) and no tag is written.
  - No other recovery is performed.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - Grant condition: |req_valid && tag_wr_vld && outstanding < MAX_OUT.
  - Winner: first i with req_valid[i]=1, scanning from the pointer upward and wrapping modulo NUM_REQ.
  - At the grant edge:
    - Register the winner index plus req_addr/req_len of that slice.
    - Pulse req_ready[winner]=1 for exactly the following cycle.
    - Set m_arvalid=1 (visible the next cycle, concurrent with req_ready).
    - Go to ISSUE.
  - If the grant condition fails, stay in IDLE. No outputs change.
- ISSUE:
  - m_araddr and m_arlen stay stable and m_arvalid stays 1 until m_arvalid && m_arready.
  - On that handshake cycle (combinational, same cycle), tag_wr_en=1 and tag_wr_data=winner.
  - At the handshake edge: m_arvalid=0, outstanding+1, pointer=(winner+1) mod NUM_REQ, go to IDLE.
- Latency and throughput:
  - Request to m_arvalid is 1 cycle.
  - Minimum 2 cycles per grant: a new grant is evaluated in the IDLE cycle after the handshake. A back-to-back AR rate of one per 2 cycles is accepted.
- Requester contract: after its req_ready pulse, a requester deasserts or presents its next request.
- Tag FIFO ordering and overflow:
  - Exactly one tag write per AR handshake, in AR order. The FIFO is AXI in-order per ID, with a single ID used.
  - Overflow is impossible: tag_wr_vld is checked at grant, and this block is the FIFO's only writer.
  - tag_wr_vld falling during ISSUE does not abort the AR.
- Outstanding counter:
  - On a handshake alone: +1. On burst_done alone: -1. On both in the same cycle: unchanged.
  - burst_done with outstanding==0 and no simultaneous handshake: counter stays 0 and err_underflow is set; it stays set until reset.
  - At outstanding==MAX_OUT: no new grant. A burst_done in the same IDLE cycle does not enable a grant until the next cycle, because the condition is registered.
- Fairness: the pointer advances only on a completed handshake. A requester dropping req_valid before its grant simply loses its turn; there is no starvation bound beyond NUM_REQ grants.
- m_arready asserted while m_arvalid=0 is ignored.

Test Plan:
- Single request: after reset, req_valid=4'b0100, req_addr[2]=28'h0001000, req_len[2]=8'h0F, m_arready=1.
  - Cycle 1: req_ready=4'b0100, m_arvalid=1, m_araddr=28'h0001000, m_arlen=8'h0F.
  - Same cycle: tag_wr_en=1, tag_wr_data=4'h2.
  - Afterwards: outstanding=1.
- Round robin: all four req_valid held high, m_arready=1 → grant order 0,1,2,3,0, tag_wr_data sequence 0,1,2,3,0, one grant every 2 cycles.
- Backpressure: hold m_arready=0 for 5 cycles during ISSUE → m_arvalid, m_araddr and m_arlen are stable for all 5 cycles, with no tag_wr_en; release → exactly one tag write.
- Outstanding limit: MAX_OUT=2, burst_done tied low, continuous requests.
  - Required: exactly 2 grants, then no further grants.
  - One burst_done pulse → exactly one further grant.
  - Handshake coinciding with burst_done → outstanding unchanged.
- FIFO full: tag_wr_vld=0 with req_valid=4'b0001 → no req_ready and m_arvalid=0 indefinitely; tag_wr_vld=1 → grant the next cycle.
- Reset and underflow:
  - burst_done pulse at outstanding=0 → err_underflow=1 and it stays set.
  - rst_n=0 during ISSUE → next cycle m_arvalid=0, outstanding=0, err_underflow=0, pointer=0 (requester 0 wins first after release).
